// File: rtl/std_cache_pkg.sv
// Shared address width and default data-cache geometry.
// Imported by the flush unit and its bench.
package riscv;
  localparam int unsigned PLEN = 56;
endpackage

package std_cache_pkg;
  localparam int unsigned PLEN                = riscv::PLEN;
  localparam int unsigned DCACHE_NUM_SETS     = 256;
  localparam int unsigned DCACHE_NUM_WAYS     = 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_TAG_WIDTH    =
    PLEN - $clog2(DCACHE_NUM_SETS) - DCACHE_OFFSET_WIDTH;
endpackage

// File: rtl/dcache_flush_unit_counter.sv
// Wrapping line-index counter; the {set,way} index with way in the low bits.
// last_o flags the final line so the sweep knows when to stop.
module counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o,
  output logic             last_o
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q_o    = r_cnt;
  assign last_o = &r_cnt;

endmodule

// File: rtl/dcache_flush_unit.sv
// Data-cache flush sweep: read every line, write back dirty ones, invalidate.
// Optional post-reset invalidate sweep enabled by DCACHE_FLUSH_INIT_EN.
module dcache_flush_unit
  import std_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS     = DCACHE_NUM_SETS,
  parameter int unsigned NUM_WAYS     = DCACHE_NUM_WAYS,
  parameter int unsigned TAG_WIDTH    = DCACHE_TAG_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DCACHE_OFFSET_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  output logic                        flush_ack_o,
  output logic                        busy_o,
  input  logic                        init_ni,
  output logic                        tag_req_o,
  input  logic                        tag_gnt_i,
  output logic                        tag_we_o,
  output logic [$clog2(NUM_SETS)-1:0] tag_set_o,
  output logic [$clog2(NUM_WAYS)-1:0] tag_way_o,
  input  logic                        tag_valid_i,
  input  logic                        tag_dirty_i,
  input  logic [TAG_WIDTH-1:0]        tag_tag_i,
  output logic                        wb_req_o,
  input  logic                        wb_gnt_i,
  output logic [riscv::PLEN-1:0]      wb_addr_o,
  input  logic                        wb_done_i
);

  localparam int unsigned SW = $clog2(NUM_SETS);
  localparam int unsigned WW = $clog2(NUM_WAYS);
  localparam int unsigned IW = SW + WW;
  localparam int unsigned AW = riscv::PLEN;
  localparam int unsigned LW = TAG_WIDTH + SW + OFFSET_WIDTH;

`ifdef DCACHE_FLUSH_INIT_EN
  typedef enum logic [2:0] {
    IDLE, INIT, READ, CHECK, WB_REQ, WB_WAIT, INVAL, ACK
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, READ, CHECK, WB_REQ, WB_WAIT, INVAL, ACK
  } state_e;
`endif

  state_e               r_state;
  state_e               w_next;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [IW-1:0]        w_idx;
  logic                 w_last;
  logic                 w_clr;
  logic                 w_inc;
  logic                 w_latch;
  logic [LW-1:0]        w_line;

  counter #(
    .WIDTH (IW)
  ) u_idx (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (w_clr),
    .en_i    (w_inc),
    .q_o     (w_idx),
    .last_o  (w_last)
  );

`ifdef DCACHE_FLUSH_INIT_EN
  logic r_first;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
    end
  end
`else
  logic w_unused_init;
  assign w_unused_init = init_ni;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_tag   <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_tag <= tag_tag_i;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    tag_req_o   = 1'b0;
    tag_we_o    = 1'b0;
    wb_req_o    = 1'b0;
    flush_ack_o = 1'b0;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      IDLE: begin
`ifdef DCACHE_FLUSH_INIT_EN
        if (r_first && !init_ni) begin
          w_next = INIT;
          w_clr  = 1'b1;
        end else
`endif
        if (flush_i) begin
          w_next = READ;
          w_clr  = 1'b1;
        end
      end
`ifdef DCACHE_FLUSH_INIT_EN
      INIT: begin
        tag_req_o = 1'b1;
        tag_we_o  = 1'b1;
        if (tag_gnt_i) begin
          w_inc = 1'b1;
          if (w_last) w_next = IDLE;
        end
      end
`endif
      READ: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) w_next = CHECK;
      end
      CHECK: begin
        if (tag_valid_i && tag_dirty_i) begin
          w_latch = 1'b1;
          w_next  = WB_REQ;
        end else if (tag_valid_i) begin
          w_next = INVAL;
        end else begin
          w_inc  = 1'b1;
          w_next = w_last ? ACK : READ;
        end
      end
      WB_REQ: begin
        wb_req_o = 1'b1;
        if (wb_gnt_i) w_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (wb_done_i) w_next = INVAL;
      end
      INVAL: begin
        tag_req_o = 1'b1;
        tag_we_o  = 1'b1;
        if (tag_gnt_i) begin
          w_inc  = 1'b1;
          w_next = w_last ? ACK : READ;
        end
      end
      ACK: begin
        flush_ack_o = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy_o    = (r_state != IDLE);
  assign tag_set_o = w_idx[IW-1:WW];
  assign tag_way_o = w_idx[WW-1:0];
  assign w_line    = {r_tag, tag_set_o, {OFFSET_WIDTH{1'b0}}};
  assign wb_addr_o = (r_state == WB_REQ) ? AW'(w_line) : '0;

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Scoreboard bench for dcache_flush_unit on a 4-set, 2-way geometry.
// Build with DCACHE_FLUSH_INIT_EN to exercise the post-reset sweep.
module tb_dcache_flush_unit;
  import std_cache_pkg::*;

  localparam int NS = 4;
  localparam int NW = 2;
  localparam int NL = NS * NW;
  localparam int OW = 4;
  localparam int PL = riscv::PLEN;
  localparam int TW = PL - 2 - OW;
  localparam int SH = 2 + OW;

  localparam int EV_RD  = 0;
  localparam int EV_WB  = 1;
  localparam int EV_INV = 2;
  localparam int EV_ACK = 3;

  typedef struct {
    int            kind;
    int            s;
    int            w;
    logic [PL-1:0] a;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          init_n = 1'b1;
  logic          flush_ack;
  logic          busy;
  logic          tag_req;
  logic          tag_gnt = 1'b0;
  logic          tag_we;
  logic [1:0]    tag_set;
  logic [0:0]    tag_way;
  logic          tag_valid = 1'b0;
  logic          tag_dirty = 1'b0;
  logic [TW-1:0] tag_tag = '0;
  logic          wb_req;
  logic          wb_gnt = 1'b0;
  logic [PL-1:0] wb_addr;
  logic          wb_done = 1'b0;

  dcache_flush_unit #(
    .NUM_SETS     (NS),
    .NUM_WAYS     (NW),
    .TAG_WIDTH    (TW),
    .OFFSET_WIDTH (OW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .flush_ack_o (flush_ack),
    .busy_o      (busy),
    .init_ni     (init_n),
    .tag_req_o   (tag_req),
    .tag_gnt_i   (tag_gnt),
    .tag_we_o    (tag_we),
    .tag_set_o   (tag_set),
    .tag_way_o   (tag_way),
    .tag_valid_i (tag_valid),
    .tag_dirty_i (tag_dirty),
    .tag_tag_i   (tag_tag),
    .wb_req_o    (wb_req),
    .wb_gnt_i    (wb_gnt),
    .wb_addr_o   (wb_addr),
    .wb_done_i   (wb_done)
  );

  always #5 clk = ~clk;

  // Tag array contents as the cache would hold them.
  logic          m_v [NL];
  logic          m_d [NL];
  logic [TW-1:0] m_t [NL];

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  int  tag_mode = 0;
  int  tag_stall = 0;
  int  wb_stall = 0;
  bit  done_en = 1'b1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_ev(input string nm, output ev_t e, output bit ok);
    n_chk++;
    ok = 1'b0;
    e  = '{-1, 0, 0, '0};
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got an event expected none", nm);
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Reference: each line in set-major, way-minor order is read; a valid
  // dirty line is written back then invalidated; a valid clean line is
  // invalidated; the sweep ends with one ack.
  function automatic void push_flush(input bit all_inv);
    for (int l = 0; l < NL; l++) begin
      int  s;
      int  w;
      ev_t e;
      s = l / NW;
      w = l % NW;
      e = '{EV_RD, s, w, '0};
      exp_q.push_back(e);
      if (!all_inv && m_v[l]) begin
        if (m_d[l]) begin
          e = '{EV_WB, s, w, (PL'(m_t[l]) << SH) | (PL'(s) << OW)};
          exp_q.push_back(e);
        end
        e = '{EV_INV, s, w, '0};
        exp_q.push_back(e);
      end
    end
    exp_q.push_back('{EV_ACK, 0, 0, '0});
  endfunction

  function automatic void fill_model(input int mode);
    for (int l = 0; l < NL; l++) begin
      m_v[l] = (mode == 0) ? 1'b0 : 1'($urandom);
      m_d[l] = 1'($urandom);
      m_t[l] = TW'({$urandom, $urandom});
    end
  endfunction

  // Responder: grants, writeback completion and read data.
  bit r_outst = 1'b0;
  int r_dcnt = 0;
  bit r_sawgnt;

  always begin
    @(negedge clk);
    r_sawgnt = wb_req && wb_gnt;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      tag_gnt = 1'b0;
      wb_gnt  = 1'b0;
      wb_done = 1'b0;
      r_outst = 1'b0;
    end else begin
      if (r_sawgnt) begin
        r_outst = 1'b1;
        r_dcnt  = $urandom_range(0, 4);
      end
      wb_done = 1'b0;
      if (r_outst && done_en) begin
        if (r_dcnt == 0) begin
          wb_done = 1'b1;
          r_outst = 1'b0;
        end else begin
          r_dcnt--;
        end
      end
      if (tag_req && tag_stall > 0) begin
        tag_gnt = 1'b0;
        tag_stall--;
      end else begin
        tag_gnt = (tag_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      if (wb_req && wb_stall > 0) begin
        wb_gnt = 1'b0;
        wb_stall--;
      end else begin
        wb_gnt = 1'($urandom);
      end
      if (wb_req && wb_gnt && !wb_done) wb_done = 1'($urandom);
      tag_valid = m_v[int'(tag_set) * NW + int'(tag_way)];
      tag_dirty = m_d[int'(tag_set) * NW + int'(tag_way)];
      tag_tag   = m_t[int'(tag_set) * NW + int'(tag_way)];
    end
  end

  // Monitor: pops the scoreboard on every handshake the DUT presents.
  logic          p_wbreq = 1'b0;
  logic          p_wbgnt = 1'b0;
  logic [PL-1:0] p_addr = '0;
  logic          p_treq = 1'b0;
  logic          p_tgnt = 1'b0;
  logic          p_we = 1'b0;
  logic [1:0]    p_set = '0;
  logic [0:0]    p_way = '0;
  logic          p_ack = 1'b0;
  bit            wb_outs = 1'b0;
  logic [PL-1:0] last_wb = '0;

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    int  idx;
    if (!rst_n) begin
      p_wbreq = 1'b0;
      p_treq  = 1'b0;
      p_ack   = 1'b0;
      wb_outs = 1'b0;
    end else begin
      if (wb_outs && wb_done) wb_outs = 1'b0;
      if (p_wbreq && !p_wbgnt) begin
        check("wb_req_held", wb_req, 1'b1);
        check("wb_addr_stable", wb_addr, p_addr);
      end
      if (p_treq && !p_tgnt) begin
        check("tag_req_held", tag_req, 1'b1);
        check("tag_we_stable", tag_we, p_we);
        check("tag_idx_stable", {tag_set, tag_way}, {p_set, p_way});
      end
      if (!wb_req) check("wb_addr_idle", wb_addr, '0);
      if (tag_req || wb_req || flush_ack) check("busy_active", busy, 1'b1);
      if (p_ack) check("ack_one_cycle", flush_ack, 1'b0);
      if (tag_req && tag_gnt) begin
        idx = int'(tag_set) * NW + int'(tag_way);
        pop_ev("tag_access", e, ok);
        if (ok) begin
          check("tag_kind", tag_we ? EV_INV : EV_RD, e.kind);
          check("tag_set", tag_set, e.s);
          check("tag_way", tag_way, e.w);
        end
        if (tag_we) begin
          check("inval_after_done", wb_outs, 1'b0);
          m_v[idx] = 1'b0;
          m_d[idx] = 1'b0;
        end
      end
      if (wb_req && wb_gnt) begin
        pop_ev("writeback", e, ok);
        if (ok) begin
          check("wb_kind", EV_WB, e.kind);
          check("wb_addr", wb_addr, e.a);
        end
        last_wb = wb_addr;
        wb_outs = 1'b1;
      end
      if (flush_ack) begin
        pop_ev("ack", e, ok);
        if (ok) check("ack_kind", EV_ACK, e.kind);
      end
      p_wbreq = wb_req;
      p_wbgnt = wb_gnt;
      p_addr  = wb_addr;
      p_treq  = tag_req;
      p_tgnt  = tag_gnt;
      p_we    = tag_we;
      p_set   = tag_set;
      p_way   = tag_way;
      p_ack   = flush_ack;
    end
  end

  task automatic check_idle_outputs(input string nm);
    check({nm, "_ack"}, flush_ack, 1'b0);
    check({nm, "_busy"}, busy, 1'b0);
    check({nm, "_reqs"}, {tag_req, tag_we, wb_req}, 3'b000);
    check({nm, "_addr"}, wb_addr, '0);
    check({nm, "_idx"}, {tag_set, tag_way}, 3'b000);
  endtask

  task automatic do_reset(input logic init_val);
    @(posedge clk);
    #2;
    rst_n  = 1'b0;
    flush  = 1'b0;
    init_n = init_val;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_flush(input bit drop_early, output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    flush = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (flush_ack) begin
        done = 1'b1;
        break;
      end
      cyc++;
      if (drop_early && cyc == 5) flush = 1'b0;
    end
    flush = 1'b0;
    check("flush_acked", done, 1'b1);
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    fill_model(0);
`ifdef DCACHE_FLUSH_INIT_EN
    do_reset(1'b0);
    @(negedge clk);
    for (int l = 0; l < NL; l++) exp_q.push_back('{EV_INV, l / NW, l % NW, '0});
    push_flush(1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("init_busy", busy, 1'b1);
      if (i == 2) flush = 1'b1;
    end
    run_flush(1'b0, cyc);
    init_n = 1'b1;
`else
    do_reset(1'b0);
    @(negedge clk);
    check_idle_outputs("reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("init_ignored", busy, 1'b0);
    end
    init_n = 1'b1;
`endif

    // All lines invalid with the tag port always granting.
    @(posedge clk);
    #2;
    tag_mode = 0;
    fill_model(0);
    push_flush(1'b0);
    run_flush(1'b0, cyc);
    check("ack_latency", cyc, 2 * NL + 1);

    // One dirty line at set 2 / way 1.
    fill_model(0);
    m_v[5] = 1'b1;
    m_d[5] = 1'b1;
    m_t[5] = TW'(5);
    push_flush(1'b0);
    run_flush(1'b0, cyc);
    check("wb_addr_line5", last_wb, PL'(56'h160));

    // Grant stalls on both ports.
    tag_mode = 1;
    fill_model(1);
    m_v[0] = 1'b1;
    m_d[0] = 1'b1;
    tag_stall = 3;
    wb_stall  = 10;
    push_flush(1'b0);
    run_flush(1'b0, cyc);

    // Randomised sweeps, some with the request dropped mid-flush.
    for (int it = 0; it < 8; it++) begin
      tag_mode = $urandom_range(0, 1);
      fill_model(1);
      push_flush(1'b0);
      run_flush(1'($urandom), cyc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
    end

    // Reset while waiting on a writeback, then a fresh sweep.
    tag_mode = 0;
    fill_model(0);
    m_v[0] = 1'b1;
    m_d[0] = 1'b1;
    done_en = 1'b0;
    push_flush(1'b0);
    flush = 1'b1;
    for (int n = 0; n < 200 && !wb_outs; n++) @(negedge clk);
    check("reached_wb_wait", wb_outs, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    done_en = 1'b1;
    @(posedge clk);
    #2;
    push_flush(1'b0);
    run_flush(1'b0, cyc);
    check("restart_latency", cyc >= 2 * NL + 1, 1'b1);

    repeat (4) begin
      @(negedge clk);
      check_idle_outputs("final_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_flush_unit.md
DCACHE_FLUSH_UNIT -- requirements
Module: dcache_flush_unit

Interface
REQ-001 SHALL have parameter NUM_SETS, default 256, number of cache sets (power of two, at least 2).
REQ-002 SHALL have parameter NUM_WAYS, default 8, ways per set (power of two, at least 2).
REQ-003 SHALL have parameter TAG_WIDTH, default 44, tag bits per line.
REQ-004 SHALL have parameter OFFSET_WIDTH, default 4, byte-offset bits per line; TAG_WIDTH+log2(NUM_SETS)+OFFSET_WIDTH equals riscv::PLEN.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port flush_i, input, 1, flush request, held high by requester until ack.
REQ-008 SHALL have port flush_ack_o, output, 1, one-cycle pulse when the flush is complete.
REQ-009 SHALL have port busy_o, output, 1, unit not idle.
REQ-010 SHALL have port init_ni, input, 1, low requests the post-reset invalidate sweep.
REQ-011 SHALL have port tag_req_o, input tag_gnt_i and output tag_we_o, each 1 bit, tag-array access handshake.
REQ-012 SHALL have port tag_set_o, output, log2(NUM_SETS), set index; port tag_way_o, output, log2(NUM_WAYS), way index.
REQ-013 SHALL have ports tag_valid_i, input, 1; tag_dirty_i, input, 1; tag_tag_i, input, TAG_WIDTH; read data, valid the cycle after a granted read.
REQ-014 SHALL have ports wb_req_o, output, 1; wb_gnt_i, input, 1; wb_addr_o, output, riscv::PLEN; wb_done_i, input, 1; line-writeback handshake.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, READ, CHECK, WB_REQ, WB_WAIT, INVAL, ACK.
REQ-016 In IDLE with flush_i=1, SHALL clear the line index to set 0 / way 0 and go to READ next cycle.
REQ-017 In READ, SHALL hold tag_req_o=1 and tag_we_o=0 until tag_gnt_i, then go to CHECK.
REQ-018 In CHECK, SHALL sample the tag data: valid&dirty goes to WB_REQ; valid&~dirty goes to INVAL; ~valid advances the index.
REQ-019 In WB_REQ, SHALL hold wb_req_o=1 with wb_addr_o={tag,set,OFFSET_WIDTH'0} stable until wb_gnt_i, then go to WB_WAIT.
REQ-020 In WB_WAIT, SHALL wait for wb_done_i, then go to INVAL; a wb_done_i arriving in the grant cycle SHALL be ignored.
REQ-021 In INVAL, SHALL hold tag_req_o=1 and tag_we_o=1 (writing valid=0, dirty=0) until tag_gnt_i, then advance the index.
REQ-022 Advance: way+1; at way NUM_WAYS-1, wrap way to 0 and set+1; at set NUM_SETS-1 / way NUM_WAYS-1, go to ACK, else go to READ.
REQ-023 ACK SHALL last exactly one cycle with flush_ack_o=1, then go to IDLE; IDLE SHALL NOT re-arm in the ACK cycle.
REQ-024 flush_i falling mid-flush SHALL be ignored; the sweep SHALL complete and ack.
REQ-025 busy_o SHALL be 1 in every state except IDLE.
REQ-026 All outputs other than those named per state SHALL be 0; tag_set_o and tag_way_o SHALL always show the current index.

Reset
REQ-027 On rst_ni low: state IDLE, index 0, all request outputs 0, flush_ack_o=0, busy_o=0; a flush in progress SHALL be abandoned.

Configuration
REQ-028 With DCACHE_FLUSH_INIT_EN defined: on the first cycle after reset release with init_ni=0, the unit SHALL go to INIT and invalidate every line (write-only, no READ or writeback), then go to IDLE without an ack; flush_i SHALL be deferred until INIT ends.
REQ-029 Without DCACHE_FLUSH_INIT_EN: the INIT state SHALL be absent, init_ni SHALL be ignored, and the unit leaves reset in IDLE.

Structure
REQ-030 The cache geometry constants SHALL come from std_cache_pkg; the FSM enum SHALL stay local to the module.
REQ-031 The combined set/way index SHALL use one common counter sub-module (counter, WIDTH = log2(NUM_SETS*NUM_WAYS)).

Verification
REQ-032 With NUM_SETS=4, NUM_WAYS=2 and all lines invalid, raise flush_i with tag_gnt_i tied 1 -> 8 reads, 0 writebacks, flush_ack_o pulses once, 8x2+1 cycles after start.
REQ-033 Line set 2 / way 1 valid, dirty, tag 0x5 -> exactly one wb_req_o with wb_addr_o = 0x5<<(log2 NUM_SETS + OFFSET_WIDTH) | 2<<OFFSET_WIDTH, followed by an INVAL write to set 2 / way 1.
REQ-034 Hold wb_gnt_i low for 10 cycles and tag_gnt_i low for 3 cycles -> request and address stay stable, nothing is skipped, ack still occurs.
REQ-035 Assert rst_ni low mid-WB_WAIT -> next cycle all outputs are 0; a new flush_i restarts at set 0 / way 0.
REQ-036 With DCACHE_FLUSH_INIT_EN defined and init_ni=0, release reset -> 8 invalidate writes, no reads, no ack, busy_o high throughout; a flush_i raised during INIT is served afterwards.
